// File: rtl/gelu_lut_pkg.sv
// rtl/gelu_lut_pkg.sv - shared defaults and FSM state type for the GELU LUT loader (checksum via GELU_LUT_CHECKSUM_EN)
package gelu_lut_pkg;

  localparam int GELU_DEPTH      = 96;
  localparam int GELU_ADDR_WIDTH = 7;
  localparam int GELU_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } lut_state_t;

endpackage

// File: rtl/gelu_lut_ram.sv
// rtl/gelu_lut_ram.sv - single write port, registered read port LUT storage without reset
module gelu_lut_ram #(
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: the loader only presents in-range addresses.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; the output holds whenever re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gelu_lut_loader.sv
// rtl/gelu_lut_loader.sv - streams a GELU table into RAM and serves 1-cycle lookups; GELU_LUT_CHECKSUM_EN adds a trailer checksum
module gelu_lut_loader
  import gelu_lut_pkg::*;
#(
  parameter int DEPTH      = GELU_DEPTH,
  parameter int ADDR_WIDTH = GELU_ADDR_WIDTH,
  parameter int DATA_WIDTH = GELU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  loaded,
  output logic                  busy,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  lut_state_t            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  wr_ready_q;
  logic                  loaded_q;
  logic                  rd_valid_q;
  logic                  rd_zero;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  accept;
  logic                  ram_we;
  logic                  ram_re;
  logic                  rd_in_range;

  assign accept      = wr_valid && wr_ready_q;
  assign ram_we      = accept && (state == ST_LOAD);
  assign rd_in_range = ({{(32-ADDR_WIDTH){1'b0}}, rd_addr} < 32'(DEPTH));
  // Out-of-range or not-yet-loaded reads never touch the array; rd_zero masks them.
  assign ram_re      = rd_en && rd_in_range && loaded_q;

`ifdef GELU_LUT_CHECKSUM_EN
  logic [15:0] sum;
  logic        err_q;
  logic [15:0] word16;
  assign word16 = 16'(wr_data);
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

  assign wr_ready = wr_ready_q;
  assign busy     = wr_ready_q;
  assign loaded   = loaded_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_zero ? '0 : ram_q;

  // Load sequencer: start only honoured when no load is in flight; counter saturates at the last entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wr_ready_q <= 1'b0;
      loaded_q   <= 1'b0;
`ifdef GELU_LUT_CHECKSUM_EN
      sum        <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_LOAD;
            cnt        <= '0;
            wr_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
`ifdef GELU_LUT_CHECKSUM_EN
            sum        <= '0;
            err_q      <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
`ifdef GELU_LUT_CHECKSUM_EN
            sum <= sum + word16;
`endif
            if (cnt == LAST_ADDR) begin
`ifdef GELU_LUT_CHECKSUM_EN
              state      <= ST_CHECK;
`else
              state      <= ST_DONE;
              wr_ready_q <= 1'b0;
              loaded_q   <= 1'b1;
`endif
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
`ifdef GELU_LUT_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            wr_ready_q <= 1'b0;
            if (word16 == sum) begin
              state    <= ST_DONE;
              loaded_q <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              err_q    <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= ST_IDLE;
          wr_ready_q <= 1'b0;
          loaded_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read qualifier: decided at the sampling edge and held with the RAM output while rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_zero    <= 1'b1;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_zero <= !loaded_q || !rd_in_range;
    end
  end

  gelu_lut_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cnt),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_gelu_lut_loader.sv
// tb/tb_gelu_lut_loader.sv - scoreboard bench for gelu_lut_loader (trailer stage exercised when GELU_LUT_CHECKSUM_EN is defined)
module tb_gelu_lut_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_en = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        loaded;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  gelu_lut_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .loaded   (loaded),
    .busy     (busy),
    .err      (err)
  );

  // Table set 0: GELU-style ramp 0x0330..0x7FFD; set 1: a distinct pattern for reloads.
  function automatic logic [15:0] word(input int set, input int i);
    if (set == 0) begin
      if (i == 0)  return 16'h0330;
      if (i == 95) return 16'h7FFD;
      return 16'(32'h0330 + i * 32'h0150);
    end
    return 16'(32'h1000 + i * 32'h0111);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid cycle consumes one expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid with data 0x%0h, no read outstanding", rd_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h", rd_data, e);
        end
      end
    end
  end

  task automatic issue_read(input int addr, input logic [15:0] exp);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = 7'(addr);
    exp_q.push_back(exp);
    @(negedge clk);
    rd_en   = 1'b0;
  endtask

  // Start a load (optionally with a same-cycle read), stream n words, optionally send a trailer.
  task automatic run_load(input int set, input bit gap, input int n, input bit poke_start,
                          input int rd_with_start, input logic [15:0] rd_exp, input bit bad_trailer);
    int i;
    int cyc;
    bit poked;
    logic [15:0] sum;
    i = 0; cyc = 0; poked = 0; sum = '0;
    @(negedge clk);
    start = 1'b1;
    if (rd_with_start >= 0) begin
      rd_en   = 1'b1;
      rd_addr = 7'(rd_with_start);
      exp_q.push_back(rd_exp);
    end
    @(negedge clk);
    start = 1'b0;
    rd_en = 1'b0;
    if (rd_with_start >= 0) check("loaded_falls_after_start", {15'd0, loaded}, 16'd0);
    while (i < n) begin
      if (cyc > 1000) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: accepted %0d of %0d words", i, n);
        break;
      end
      wr_valid = !(gap && (cyc % 2 == 1));
      wr_data  = word(set, i);
      start    = poke_start && !poked && (i == 40);
      if (start) poked = 1;
      if (wr_valid && wr_ready) begin
        sum = sum + wr_data;
        if (i == n - 1 && n == 96) check("busy_on_last_accept", {15'd0, busy}, 16'd1);
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
`ifdef GELU_LUT_CHECKSUM_EN
    if (n == 96) begin
      wr_valid = 1'b1;
      wr_data  = bad_trailer ? sum + 16'd1 : sum;
      check("ready_for_trailer", {15'd0, wr_ready}, 16'd1);
      @(negedge clk);
    end
`else
    if (bad_trailer) check("unused_trailer", 16'd0, {15'd0, err});
`endif
    wr_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_loaded",   {15'd0, loaded},   16'd0);
    check("rst_busy",     {15'd0, busy},     16'd0);
    check("rst_wr_ready", {15'd0, wr_ready}, 16'd0);
    check("rst_err",      {15'd0, err},      16'd0);
    check("rst_rd_valid", {15'd0, rd_valid}, 16'd0);
    check("rst_rd_data",  rd_data,           16'd0);
    rst_n = 1'b1;

    // Read before any load returns zero with rd_valid.
    issue_read(3, 16'h0000);

    // Full continuous load of set 0.
    run_load(0, 0, 96, 0, -1, 16'h0, 0);
    check("busy_drop", {15'd0, busy},   16'd0);
    check("loaded_1",  {15'd0, loaded}, 16'd1);
    check("err_0",     {15'd0, err},    16'd0);
    issue_read(0, 16'h0330);
    issue_read(95, 16'h7FFD);
    issue_read(100, 16'h0000);

    // Reload with same-cycle read, gapped writes, stray start at word 40.
    run_load(1, 1, 96, 1, 10, word(0, 10), 0);
    check("busy_drop_gapped", {15'd0, busy},   16'd0);
    check("loaded_gapped",    {15'd0, loaded}, 16'd1);
    @(negedge clk);
    for (int a = 0; a < 96; a++) begin
      rd_en   = 1'b1;
      rd_addr = 7'(a);
      exp_q.push_back(word(1, a));
      @(negedge clk);
    end
    rd_en = 1'b0;

    // Reset in the middle of a load.
    run_load(0, 0, 40, 0, -1, 16'h0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midload_loaded", {15'd0, loaded}, 16'd0);
    check("midload_busy",   {15'd0, busy},   16'd0);
    issue_read(5, 16'h0000);

`ifdef GELU_LUT_CHECKSUM_EN
    run_load(0, 0, 96, 0, -1, 16'h0, 0);
    check("cks_good_loaded", {15'd0, loaded}, 16'd1);
    check("cks_good_err",    {15'd0, err},    16'd0);
    run_load(0, 0, 96, 0, -1, 16'h0, 1);
    check("cks_bad_err",    {15'd0, err},    16'd1);
    check("cks_bad_loaded", {15'd0, loaded}, 16'd0);
    check("cks_bad_idle",   {15'd0, busy},   16'd0);
    issue_read(0, 16'h0000);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
